// File: rtl/ay_pkg.sv
// Shared definitions for the AY-3-8913 core: envelope width, shape bit indices,
// envelope state encoding and register-file indices of the envelope registers.
// Define AY_ENVELOPE_YM32_EN for YM2149-style 32-step envelopes.
package ay_pkg;

`ifdef AY_ENVELOPE_YM32_EN
    // Twice the steps per ramp, so one fewer prescale bit keeps the ramp duration.
    localparam int ENV_BITS     = 5;
    localparam int PRESCALE_ADJ = 1;
`else
    localparam int ENV_BITS     = 4;
    localparam int PRESCALE_ADJ = 0;
`endif

    // Bit positions of the shape nibble {continue, attack, alternate, hold}.
    localparam int SHAPE_CONTINUE  = 3;
    localparam int SHAPE_ATTACK    = 2;
    localparam int SHAPE_ALTERNATE = 1;
    localparam int SHAPE_HOLD      = 0;

    typedef enum logic {
        RAMP = 1'b0,
        HOLD = 1'b1
    } env_state_t;

    // Register-file indices feeding this block.
    localparam logic [3:0] R_ENV_LO    = 4'd11;
    localparam logic [3:0] R_ENV_HI    = 4'd12;
    localparam logic [3:0] R_ENV_SHAPE = 4'd13;

endpackage

// File: rtl/ay_period_counter.sv
// Tick-gated period counter; raises step on the tick that reaches period_eff-1.
// Latency: step is combinational from tick and the current count.
// Backpressure: none; the count free-runs on tick and is cleared by clear.
//
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   tick            advance enable (one cycle per prescaler wrap)
//   clear           restart the count from 0; suppresses step on that cycle
//   period          period in ticks; 0 behaves as 1
//   step            one-cycle pulse at the end of each period
module ay_period_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             clear,
    input  logic [WIDTH-1:0] period,
    output logic             step
);

    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] limit;
    logic             at_limit;

    // period_eff - 1 with period 0 treated as 1.
    assign limit = (period == '0) ? '0 : period - WIDTH'(1);

    // >= rather than == so that a period lowered below the running count
    // ends the period on the very next tick instead of wrapping the counter.
    assign at_limit = (count >= limit);
    assign step     = tick & ~clear & at_limit;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (tick) begin
            count <= at_limit ? '0 : count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/ay_envelope.sv
// AY-3-8913 envelope generator: prescaler, period counter and ramp/hold FSM for all 16 shapes.
// Latency: restart at edge N shows the first ramp value and holding=0 after edge N+1.
// Backpressure: none; free-running, re-phased only by restart.
//
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   period                           envelope period (0 behaves as 1)
//   shape_continue/attack/alternate/hold   live shape bits from the register file
//   restart                          one-cycle pulse when the shape register is written
//   envelope                         registered amplitude, ENV_BITS wide
//   holding                          registered, high while the FSM is in HOLD
// Build option: AY_ENVELOPE_YM32_EN selects 32-step envelopes (see ay_pkg).
module ay_envelope
    import ay_pkg::*;
#(
    parameter int PRESCALE_BITS = 4,
    parameter int PERIOD_BITS   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [PERIOD_BITS-1:0] period,
    input  logic                   shape_continue,
    input  logic                   shape_attack,
    input  logic                   shape_alternate,
    input  logic                   shape_hold,
    input  logic                   restart,
    output logic [ENV_BITS-1:0]    envelope,
    output logic                   holding
);

    localparam int                  PS_BITS  = PRESCALE_BITS - PRESCALE_ADJ;
    localparam logic [ENV_BITS-1:0] STEP_MAX = '1;

    logic [3:0] shape;
    assign shape = {shape_continue, shape_attack, shape_alternate, shape_hold};

    // ------------------------------------------------------------------
    // Time base
    // ------------------------------------------------------------------
    logic [PS_BITS-1:0] prescale;
    logic               tick;
    logic               step;

    always_ff @(posedge clk) begin
        if (reset) begin
            prescale <= '0;
        end else if (restart) begin
            prescale <= '0;
        end else begin
            prescale <= prescale + PS_BITS'(1);
        end
    end

    assign tick = &prescale;

    ay_period_counter #(
        .WIDTH (PERIOD_BITS)
    ) u_period (
        .clk    (clk),
        .reset  (reset),
        .tick   (tick),
        .clear  (restart),
        .period (period),
        .step   (step)
    );

    // ------------------------------------------------------------------
    // Ramp / hold state machine
    // ------------------------------------------------------------------
    env_state_t          state, state_nxt;
    logic [ENV_BITS-1:0] step_cnt, step_cnt_nxt;
    logic                invert, invert_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= HOLD;
            step_cnt <= '0;
            invert   <= 1'b0;
        end else begin
            state    <= state_nxt;
            step_cnt <= step_cnt_nxt;
            invert   <= invert_nxt;
        end
    end

    // The held value is encoded in step_cnt/invert so the output path is the
    // same XOR in both states:
    //   no continue      -> step_cnt=0, invert=0         (output 0)
    //   continue + hold  -> step_cnt=max, invert^=alt    (last value, flipped if alternate)
    always_comb begin
        state_nxt    = state;
        step_cnt_nxt = step_cnt;
        invert_nxt   = invert;
        if (restart) begin
            state_nxt    = RAMP;
            step_cnt_nxt = '0;
            invert_nxt   = ~shape[SHAPE_ATTACK];
        end else if (state == RAMP && step) begin
            if (step_cnt != STEP_MAX) begin
                step_cnt_nxt = step_cnt + ENV_BITS'(1);
            end else if (!shape[SHAPE_CONTINUE]) begin
                state_nxt    = HOLD;
                step_cnt_nxt = '0;
                invert_nxt   = 1'b0;
            end else if (shape[SHAPE_HOLD]) begin
                state_nxt  = HOLD;
                invert_nxt = invert ^ shape[SHAPE_ALTERNATE];
            end else begin
                step_cnt_nxt = '0;
                invert_nxt   = invert ^ shape[SHAPE_ALTERNATE];
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs: decoded combinationally, then registered
    // ------------------------------------------------------------------
    logic [ENV_BITS-1:0] envelope_nxt;
    logic                holding_nxt;

    always_comb begin
        envelope_nxt = step_cnt ^ {ENV_BITS{invert}};
        holding_nxt  = (state == HOLD);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            envelope <= '0;
            holding  <= 1'b1;
        end else begin
            envelope <= envelope_nxt;
            holding  <= holding_nxt;
        end
    end

endmodule

// File: tb/tb_ay_envelope.sv
// Self-checking bench for ay_envelope: directed shape/period scenarios followed
// by randomized shape/period/restart runs, compared every cycle against a
// waveform-level reference model through an expected-value queue.
module tb_ay_envelope;
    import ay_pkg::*;

    localparam int STEPS    = 2 ** ENV_BITS;
    localparam int TICK_LEN = 2 ** (4 - PRESCALE_ADJ);
    localparam int WATCHDOG_CYCLES = 2_000_000;

    typedef struct {
        logic [ENV_BITS-1:0] env;
        logic                hold;
    } exp_t;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic [15:0]         period = 16'd1;
    logic                shape_continue = 1'b0;
    logic                shape_attack = 1'b0;
    logic                shape_alternate = 1'b0;
    logic                shape_hold = 1'b0;
    logic                restart = 1'b0;
    logic [ENV_BITS-1:0] envelope;
    logic                holding;

    int   checks = 0;
    int   errors = 0;
    bit   done = 1'b0;
    exp_t exp_q[$];

    ay_envelope #(
        .PRESCALE_BITS (4),
        .PERIOD_BITS   (16)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .period          (period),
        .shape_continue  (shape_continue),
        .shape_attack    (shape_attack),
        .shape_alternate (shape_alternate),
        .shape_hold      (shape_hold),
        .restart         (restart),
        .envelope        (envelope),
        .holding         (holding)
    );

    always #5 clk = ~clk;

    // Envelope waveform after k steps since restart, straight from the shape table.
    function automatic void shape_value(input logic [3:0] shp, input int k,
                                        output int val, output bit hold);
        int  cyc  = k / STEPS;
        int  pos  = k % STEPS;
        bit  cont = shp[3];
        bit  att  = shp[2];
        bit  alt  = shp[1];
        bit  hb   = shp[0];
        if (cyc == 0) begin
            val  = att ? pos : STEPS - 1 - pos;
            hold = 1'b0;
        end else if (!cont) begin
            val  = 0;
            hold = 1'b1;
        end else if (hb) begin
            val  = (att ^ alt) ? STEPS - 1 : 0;
            hold = 1'b1;
        end else begin
            val  = (att ^ (alt && (cyc % 2 == 1))) ? pos : STEPS - 1 - pos;
            hold = 1'b0;
        end
    endfunction

    // Reference model: tracks steps since restart as plain integers and
    // queues the output expected to be visible after each clock edge.
    bit         m_active = 1'b0;
    int         m_steps = 0;
    int         m_ticks = 0;
    int         m_edges = 0;
    logic [3:0] m_shape = 4'd0;

    initial begin : model
        exp_t e;
        int   val;
        bit   hb;
        int   pe;
        forever begin
            @(posedge clk);
            if (reset || !m_active) begin
                e.env  = '0;
                e.hold = 1'b1;
            end else begin
                shape_value(m_shape, m_steps, val, hb);
                e.env  = ENV_BITS'(val);
                e.hold = hb;
            end
            exp_q.push_back(e);

            if (reset) begin
                m_active = 1'b0;
            end else if (restart) begin
                m_active = 1'b1;
                m_steps  = 0;
                m_ticks  = 0;
                m_edges  = 0;
                m_shape  = {shape_continue, shape_attack, shape_alternate, shape_hold};
            end else if (m_active) begin
                m_edges++;
                if (m_edges % TICK_LEN == 0) begin
                    pe = (period == 16'd0) ? 1 : int'(period);
                    if (m_ticks >= pe - 1) begin
                        m_ticks = 0;
                        m_steps++;
                    end else begin
                        m_ticks++;
                    end
                end
            end
        end
    end

    // Monitor: one comparison per cycle, away from the active edge.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (envelope !== e.env || holding !== e.hold) begin
                    errors++;
                    $display("FAIL env_out @%0t: got envelope=%0d holding=%0b, expected envelope=%0d holding=%0b",
                             $time, envelope, holding, e.env, e.hold);
                end
            end
        end
    end

    // Watchdog: the driver must finish within a bounded number of cycles.
    initial begin : watchdog
        int waited = 0;
        while (!done && waited < WATCHDOG_CYCLES) begin
            @(posedge clk);
            waited++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL timeout @%0t: driver did not finish within %0d cycles",
                     $time, WATCHDOG_CYCLES);
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_reset_state(input string tag);
        checks++;
        if (envelope !== '0 || holding !== 1'b1) begin
            errors++;
            $display("FAIL reset_state %s @%0t: got envelope=%0d holding=%0b, expected envelope=0 holding=1",
                     tag, $time, envelope, holding);
        end
    endtask

    task automatic do_restart(input logic [3:0] shp, input logic [15:0] p);
        shape_continue  = shp[3];
        shape_attack    = shp[2];
        shape_alternate = shp[1];
        shape_hold      = shp[0];
        period          = p;
        restart         = 1'b1;
        @(negedge clk);
        restart         = 1'b0;
    endtask

    initial begin : driver
        logic [3:0] shp;
        logic [15:0] p;

        // Reset, then a long idle stretch: envelope 0, holding 1.
        cycles(3);
        check_reset_state("in_reset");
        reset = 1'b0;
        cycles(1000);
        check_reset_state("after_idle");

        // Sawtooth up, period 1: two full ramps plus a wrap.
        do_restart(4'b1100, 16'd1);
        cycles(2 * STEPS * TICK_LEN + 40);

        // Triangle starting downward, period 2.
        do_restart(4'b1010, 16'd2);
        cycles(2 * STEPS * TICK_LEN * 2 + 40);

        // Attack then hold at max; decay then hold at 0.
        do_restart(4'b1101, 16'd1);
        cycles(STEPS * TICK_LEN + 100);
        do_restart(4'b0000, 16'd1);
        cycles(STEPS * TICK_LEN + 100);

        // Restart landing on the same edge as the 7->8 step.
        do_restart(4'b1100, 16'd1);
        cycles(8 * TICK_LEN - 1);
        do_restart(4'b1100, 16'd1);
        cycles(3 * TICK_LEN);

        // Period drops from 100 to 0 with the count around 50.
        do_restart(4'b1100, 16'd100);
        cycles(50 * TICK_LEN + 5);
        period = 16'd0;
        cycles(20 * TICK_LEN);

        // Randomized shapes, periods and restart timing, with one mid-run reset.
        for (int i = 0; i < 12; i++) begin
            shp = 4'($urandom_range(0, 15));
            p   = 16'($urandom_range(0, 3));
            do_restart(shp, p);
            cycles($urandom_range(20, 3 * STEPS * TICK_LEN));
            if (i == 6) begin
                reset = 1'b1;
                cycles(2);
                reset = 1'b0;
                cycles(50);
            end
        end

        cycles(3);
        done = 1'b1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
